chan_arbiter: RTL and testbench



---
 rtl/chan_arb_pkg.sv | 30 +++
 rtl/chan_arbiter.sv | 143 ++++++++++++++
 tb/tb_chan_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_arb_pkg.sv
// Shared constants, control-word field helpers and FSM state type for chan_arbiter.
package chan_arb_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CW_FLAG_BIT = 15;
    localparam int unsigned CW_CH_MSB   = 14;
    localparam int unsigned CW_CH_LSB   = 9;
    localparam int unsigned CW_LEN_MSB  = 8;
    localparam int unsigned CH_FIELD_W  = CW_CH_MSB - CW_CH_LSB + 1;
    localparam int unsigned LEN_W       = 9;

    localparam logic [DATA_W-1:0] PAD_WORD = 16'h0000;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_t;

    // Source channel recorded in a control word.
    function automatic logic [CH_FIELD_W-1:0] cw_chan(input logic [DATA_W-1:0] w);
        return w[CW_CH_MSB:CW_CH_LSB];
    endfunction

    // Remaining data words announced by a control word.
    function automatic logic [LEN_W-1:0] cw_len(input logic [DATA_W-1:0] w);
        return w[CW_LEN_MSB:0];
    endfunction

endpackage

// File: rtl/chan_arbiter.sv
// Round-robin block arbiter: polls NCH channel FIFOs and forwards whole blocks as one stream.
// Optional stall timeout with zero padding: define CHAN_ARB_TIMEOUT_EN (parameter TMO).
module chan_arbiter
    import chan_arb_pkg::*;
#(
    parameter int unsigned NCH   = 16,
    parameter int unsigned PBITS = 4
`ifdef CHAN_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TMO   = 255
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [NCH-1:0]    give,
    input  logic [NCH-1:0]    have,
    input  logic [DATA_W-1:0] din,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] dout,
    output logic              dvld,
    output logic              dsof,
    output logic              deof,
    output logic [PBITS-1:0]  cur_ch,
    output logic [15:0]       blk_cnt,
    output logic              err
);

    localparam logic [PBITS-1:0] LAST_CH = PBITS'(NCH - 1);

`ifdef CHAN_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = (TMO > 1) ? $clog2(TMO + 1) : 1;
    logic [STALL_W-1:0] stall;
`endif

    state_t           state;
    logic [LEN_W-1:0] rem;
    logic [NCH-1:0]   sel;
    logic             hv;
    logic             take;
    logic             is_cw;
    logic [LEN_W-1:0] len_in;
    logic [PBITS-1:0] nxt_ch;

    // One-hot decode of the pointer; give is withheld while stalled, padding or in reset.
    assign sel    = NCH'(1) << cur_ch;
    assign hv     = |(have & sel);
    assign give   = (rst_n && out_rdy && (state != PAD)) ? sel : '0;
    assign take   = hv && out_rdy && (state != PAD);
    assign is_cw  = din[CW_FLAG_BIT];
    assign len_in = cw_len(din);
    assign nxt_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            rem     <= '0;
            cur_ch  <= '0;
            dout    <= '0;
            dvld    <= 1'b0;
            dsof    <= 1'b0;
            deof    <= 1'b0;
            err     <= 1'b0;
            blk_cnt <= '0;
`ifdef CHAN_ARB_TIMEOUT_EN
            stall   <= '0;
`endif
        end else begin
            dvld <= 1'b0;
            dsof <= 1'b0;
            deof <= 1'b0;
            err  <= 1'b0;
            case (state)
                SCAN: begin
                    if (take) begin
                        if (is_cw) begin
                            dout <= din;
                            dvld <= 1'b1;
                            dsof <= 1'b1;
                            rem  <= len_in;
                            if (len_in == '0) begin
                                deof    <= 1'b1;
                                blk_cnt <= blk_cnt + 1'b1;
                                cur_ch  <= nxt_ch;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            // Not a block start: drop it and keep polling this channel to resync.
                            err <= 1'b1;
                        end
                    end else if (out_rdy) begin
                        cur_ch <= nxt_ch;
                    end
                end
                DATA: begin
                    if (take) begin
                        dout <= din;
                        dvld <= 1'b1;
                        err  <= is_cw;
                        rem  <= rem - 1'b1;
`ifdef CHAN_ARB_TIMEOUT_EN
                        stall <= '0;
`endif
                        if (rem == LEN_W'(1)) begin
                            deof    <= 1'b1;
                            blk_cnt <= blk_cnt + 1'b1;
                            cur_ch  <= nxt_ch;
                            state   <= SCAN;
                        end
                    end
`ifdef CHAN_ARB_TIMEOUT_EN
                    else if (out_rdy) begin
                        if (stall == STALL_W'(TMO - 1)) begin
                            err   <= 1'b1;
                            stall <= '0;
                            state <= PAD;
                        end else begin
                            stall <= stall + 1'b1;
                        end
                    end
`endif
                end
`ifdef CHAN_ARB_TIMEOUT_EN
                // Close the abandoned block with zero words so downstream framing stays intact.
                PAD: begin
                    if (out_rdy) begin
                        dout <= PAD_WORD;
                        dvld <= 1'b1;
                        rem  <= rem - 1'b1;
                        if (rem == LEN_W'(1)) begin
                            deof   <= 1'b1;
                            cur_ch <= nxt_ch;
                            state  <= SCAN;
                        end
                    end
                end
`endif
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_arbiter.sv
// Self-checking bench for chan_arbiter: directed vector table, corner sequences, randomized run.
module tb_chan_arbiter;
    import chan_arb_pkg::*;

    localparam int unsigned NCH   = 16;
    localparam int unsigned PBITS = 4;
    localparam int unsigned DEPTH = 128;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NCH-1:0]    give;
    logic [NCH-1:0]    have;
    logic [15:0]       din;
    logic              out_rdy;
    logic [15:0]       dout;
    logic              dvld, dsof, deof, err;
    logic [PBITS-1:0]  cur_ch;
    logic [15:0]       blk_cnt;

    always #5 clk = ~clk;

    chan_arbiter #(
        .NCH   (NCH),
        .PBITS (PBITS)
`ifdef CHAN_ARB_TIMEOUT_EN
        ,
        .TMO   (8)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .give    (give),
        .have    (have),
        .din     (din),
        .out_rdy (out_rdy),
        .dout    (dout),
        .dvld    (dvld),
        .dsof    (dsof),
        .deof    (deof),
        .cur_ch  (cur_ch),
        .blk_cnt (blk_cnt),
        .err     (err)
    );

    // Channel FIFO models: words written by the test, read pointer advanced on give&have.
    logic [15:0]    mem [NCH][DEPTH];
    logic [6:0]     wr  [NCH] = '{default: '0};
    logic [6:0]     rd  [NCH];
    logic           rand_mode = 1'b0;
    logic [NCH-1:0] hv_rand   = '1;

    always_comb begin
        have = '0;
        din  = '0;
        for (int i = 0; i < NCH; i++) begin
            if ((rd[i] != wr[i]) && (mem[i][rd[i]][15] || !rand_mode || hv_rand[i]))
                have[i] = 1'b1;
            if (give[i] && have[i])
                din = mem[i][rd[i]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) rd[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (give[i] && have[i]) rd[i] <= rd[i] + 7'd1;
        end
    end

    // Output monitor, sampled mid-cycle.
    typedef struct {
        logic [15:0]      w;
        logic             sof;
        logic             eof;
        logic [PBITS-1:0] ch;
        logic [15:0]      blk;
        int               cyc;
    } obs_t;

    obs_t got[$];
    int   cyc      = 0;
    int   err_cnt  = 0;
    int   err_cyc  = 0;
    int   gate_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (dvld) got.push_back('{dout, dsof, deof, cur_ch, blk_cnt, cyc});
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if ((!out_rdy || !rst_n) && (give != '0)) gate_bad++;
        if ($countones(give) > 1) gate_bad++;
        if ((dsof || deof) && !dvld) gate_bad++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input logic [15:0] w);
        mem[ch][wr[ch]] = w;
        wr[ch] = wr[ch] + 7'd1;
    endtask

    function automatic logic [15:0] data_word(input int ch, input int k, input bit flag);
        logic [15:0] w;
        w = 16'(ch * 256 + k);
        if (flag && k == 1) w[15] = 1'b1;
        return w;
    endfunction

    // Assert reset and empty all channels; caller loads data then calls release_rst.
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n     = 1'b0;
        out_rdy   = 1'b1;
        rand_mode = 1'b0;
        hv_rand   = '1;
        for (int i = 0; i < NCH; i++) wr[i] = '0;
        @(posedge clk); #2;
    endtask

    task automatic release_rst();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int max_cyc, input bit rnd, input string name);
        int k;
        k = 0;
        while (got.size() < n && k < max_cyc) begin
            @(posedge clk); #2;
            if (rnd) begin
                hv_rand = NCH'($urandom);
                out_rdy = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            k++;
        end
        check({name, "_reached"}, 32'(got.size() >= n), 1);
        if (rnd) begin
            @(posedge clk); #2;
            out_rdy = 1'b1;
            hv_rand = '1;
        end
    endtask

    typedef struct {
        int          ch;
        logic [15:0] cw;
        bit          junk;
        bit          flag_mid;
        int          n_words;
        int          n_err;
        int          cur_after;
    } vec_t;

    task automatic test_table();
        vec_t vt[4];
        int   base, e0, len, last;
        vt[0] = '{3,  16'h8605, 1'b0, 1'b0, 6, 0, 4};
        vt[1] = '{2,  16'h8401, 1'b1, 1'b0, 2, 1, 3};
        vt[2] = '{5,  16'h8A00, 1'b0, 1'b0, 1, 0, 6};
        vt[3] = '{15, 16'h9E02, 1'b0, 1'b1, 3, 1, 0};
        for (int v = 0; v < 4; v++) begin
            base = got.size();
            e0   = err_cnt;
            len  = int'(vt[v].cw[8:0]);
            @(posedge clk); #2;
            if (vt[v].junk) push(vt[v].ch, 16'h1234);
            push(vt[v].ch, vt[v].cw);
            for (int k = 1; k <= len; k++) push(vt[v].ch, data_word(vt[v].ch, k, vt[v].flag_mid));
            run_until(base + vt[v].n_words, 100, 1'b0, "tbl");
            repeat (3) @(negedge clk);
            check("tbl_len", 32'(got.size() - base), 32'(vt[v].n_words));
            check("tbl_err", 32'(err_cnt - e0), 32'(vt[v].n_err));
            if (got.size() >= base + vt[v].n_words) begin
                last = base + vt[v].n_words - 1;
                check("tbl_cw", got[base].w, vt[v].cw);
                check("tbl_sof", got[base].sof, 1);
                for (int k = 1; k < vt[v].n_words; k++) begin
                    check("tbl_data", got[base + k].w, data_word(vt[v].ch, k, vt[v].flag_mid));
                    check("tbl_sof_mid", got[base + k].sof, 0);
                end
                for (int k = 0; k < vt[v].n_words; k++)
                    check("tbl_eof", got[base + k].eof, 32'(k == vt[v].n_words - 1));
                check("tbl_blk", got[last].blk, 32'(v + 1));
                check("tbl_cur", got[last].ch, 32'(vt[v].cur_after));
            end
        end
    endtask

    task automatic test_interleave();
        logic [15:0] ew[8] = '{16'h8003, 16'h0A01, 16'h0A02, 16'h0A03,
                               16'h8203, 16'h0B01, 16'h0B02, 16'h0B03};
        do_reset();
        for (int k = 0; k < 8; k++) push(k / 4, ew[k]);
        release_rst();
        rand_mode = 1'b1;
        run_until(8, 400, 1'b1, "ilv");
        repeat (3) @(negedge clk);
        rand_mode = 1'b0;
        check("ilv_len", 32'(got.size()), 8);
        if (got.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("ilv_word", got[k].w, ew[k]);
                check("ilv_eof", got[k].eof, 32'((k % 4) == 3));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        push(0, 16'h8005);
        for (int k = 1; k <= 5; k++) push(0, 16'h0C00 + 16'(k));
        release_rst();
        run_until(2, 50, 1'b0, "stl_pre");
        @(posedge clk); #2;
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stl_give", give, 0);
            if (k > 0) check("stl_dvld", dvld, 0);
            @(posedge clk); #2;
        end
        out_rdy = 1'b1;
        run_until(6, 50, 1'b0, "stl");
        repeat (3) @(negedge clk);
        check("stl_len", 32'(got.size()), 6);
        check("stl_rd", rd[0], 6);
        if (got.size() >= 6) begin
            check("stl_cw", got[0].w, 16'h8005);
            for (int k = 1; k < 6; k++) check("stl_word", got[k].w, 16'h0C00 + 16'(k));
            check("stl_eof", got[5].eof, 1);
            check("stl_blk", got[5].blk, 1);
        end
    endtask

    typedef struct {
        logic [15:0] w;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[NCH][$];
    int          blen[NCH][$];

    // Reference: every channel queues whole blocks; the arbiter serves one block per channel per lap.
    task automatic test_random();
        int          nb, len, total_blk, left, c, e0;
        logic [15:0] w;
        do_reset();
        exp_q.delete();
        total_blk = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            mq[ch].delete();
            blen[ch].delete();
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
                len = $urandom_range(0, 6);
                w   = 16'h8000 | 16'(ch << 9) | 16'(len);
                push(ch, w);
                mq[ch].push_back(w);
                for (int k = 0; k < len; k++) begin
                    w = 16'($urandom) & 16'h7FFF;
                    push(ch, w);
                    mq[ch].push_back(w);
                end
                blen[ch].push_back(len);
                total_blk++;
            end
        end
        left = total_blk;
        c    = 0;
        while (left > 0) begin
            if (blen[c].size() > 0) begin
                len = blen[c].pop_front();
                for (int k = 0; k <= len; k++) exp_q.push_back('{mq[c].pop_front(), k == 0, k == len});
                left--;
            end
            c = (c + 1) % NCH;
        end
        e0 = err_cnt;
        release_rst();
        rand_mode = 1'b1;
        run_until(exp_q.size(), 4000, 1'b1, "rnd");
        repeat (3) @(negedge clk);
        rand_mode = 1'b0;
        check("rnd_len", 32'(got.size()), 32'(exp_q.size()));
        check("rnd_err", 32'(err_cnt - e0), 0);
        check("rnd_blk", blk_cnt, 32'(total_blk));
        if (got.size() >= exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check("rnd_word", got[i].w, exp_q[i].w);
                check("rnd_sof", got[i].sof, exp_q[i].sof);
                check("rnd_eof", got[i].eof, exp_q[i].eof);
            end
        end
    endtask

`ifdef CHAN_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        do_reset();
        push(0, 16'h8005);
        push(0, 16'h0D01);
        push(0, 16'h0D02);
        e0 = err_cnt;
        release_rst();
        run_until(6, 100, 1'b0, "tmo");
        repeat (3) @(negedge clk);
        check("tmo_len", 32'(got.size()), 6);
        check("tmo_err", 32'(err_cnt - e0), 1);
        if (got.size() >= 6) begin
            check("tmo_d2", got[2].w, 16'h0D02);
            check("tmo_delay", 32'(err_cyc - got[2].cyc), 8);
            for (int k = 3; k < 6; k++) begin
                check("tmo_pad", got[k].w, 16'h0000);
                check("tmo_pad_sof", got[k].sof, 0);
                check("tmo_pad_eof", got[k].eof, 32'(k == 5));
            end
            check("tmo_blk", got[5].blk, 0);
            check("tmo_cur", got[5].ch, 1);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_rdy = 1'b1;
        #1;
        rst_n = 1'b0;
        push(0, 16'h8000);
        repeat (2) @(negedge clk);
        check("rst_give", give, 0);
        check("rst_dout", dout, 0);
        check("rst_dvld", dvld, 0);
        check("rst_dsof", dsof, 0);
        check("rst_deof", deof, 0);
        check("rst_err", err, 0);
        check("rst_blk", blk_cnt, 0);
        check("rst_cur", cur_ch, 0);
        do_reset();
        release_rst();
        test_table();
        got.delete();
        test_interleave();
        got.delete();
        test_stall();
        got.delete();
        test_random();
`ifdef CHAN_ARB_TIMEOUT_EN
        got.delete();
        test_timeout();
`endif
        check("gating", 32'(gate_bad), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
